// File: rtl/cke_sched_pkg.sv
// cke_sched_pkg: shared types and helpers for the clock-enable scheduler.
// Build option: CKE_SCHED_ONESHOT_EN enables the one-shot channel mode.
package cke_sched_pkg;

  typedef enum logic [1:0] {
    STOP           = 2'b00,
    START_PERIODIC = 2'b01,
    START_ONESHOT  = 2'b10,
    RSVD           = 2'b11
  } cke_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    ONESHOT = 2'b10
  } cke_ch_state_t;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cke_cfg_state_t;

  // True for either flavour of START; these ops carry a period.
  function automatic logic is_start(input cke_op_t op);
    return (op == START_PERIODIC) || (op == START_ONESHOT);
  endfunction

  // True when this build knows how to execute the op.
  function automatic logic op_legal(input cke_op_t op);
`ifdef CKE_SCHED_ONESHOT_EN
    return op != RSVD;
`else
    return (op == STOP) || (op == START_PERIODIC);
`endif
  endfunction

endpackage

// File: rtl/cke_sched_ch.sv
// cke_sched_ch: one scheduler channel (state, period register, tick counter,
// pulse decode). ONESHOT mode exists only when CKE_SCHED_ONESHOT_EN is defined.
module cke_sched_ch
  import cke_sched_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          base_tick,
  input  logic          apply,
  input  cke_op_t       op,
  input  logic [PW-1:0] period,
  output logic          gen,
  output logic          active
);

  cke_ch_state_t state, state_nx;
  logic [PW-1:0] p, p_nx;
  logic [PW-1:0] cnt, cnt_nx;
  logic          at_end;

  assign at_end = (cnt == (p - PW'(1)));
  assign active = (state != IDLE);
  // An apply in the same cycle owns the channel, so the tick pulse is dropped.
  assign gen    = base_tick & active & at_end & ~apply;

  // Channel registers; all cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      p     <= p_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: a config apply takes priority over counting the base tick.
  always_comb begin
    state_nx = state;
    p_nx     = p;
    cnt_nx   = cnt;
    if (apply) begin
      case (op)
        STOP: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
        START_PERIODIC: begin
          state_nx = RUN;
          p_nx     = period;
          cnt_nx   = '0;
        end
`ifdef CKE_SCHED_ONESHOT_EN
        START_ONESHOT: begin
          state_nx = ONESHOT;
          p_nx     = period;
          cnt_nx   = '0;
        end
`endif
        default: ;
      endcase
    end else if (base_tick && active) begin
      if (at_end) begin
        cnt_nx = '0;
`ifdef CKE_SCHED_ONESHOT_EN
        if (state == ONESHOT) state_nx = IDLE;
`endif
      end else begin
        cnt_nx = cnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/cke_sched.sv
// cke_sched: shared base prescaler, valid/ready config FSM and NCH
// clock-enable channels. Build option: CKE_SCHED_ONESHOT_EN (one-shot mode).
module cke_sched
  import cke_sched_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int PRE_DIV = 50,
  parameter  int PW      = 16,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_op,
  input  logic [PW-1:0]  cfg_period,
  output logic           cfg_err,
  output logic [NCH-1:0] gen,
  output logic           busy
);

  localparam int PREW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [PREW-1:0] pre_cnt;
  logic            base_tick;

  cke_cfg_state_t  cfg_state, cfg_nx;
  cke_op_t         cmd_op;
  logic [CHW-1:0]  cmd_ch;
  logic [PW-1:0]   cmd_period;

  logic [NCH-1:0]  ch_hit;
  logic [NCH-1:0]  ch_apply;
  logic [NCH-1:0]  ch_active;
  logic            in_apply;
  logic            reject;

  // With PRE_DIV=1 the counter sits at 0 and base_tick stays high.
  assign base_tick = (pre_cnt == PREW'(PRE_DIV - 1));

  // Free-running base prescaler; commands never touch its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pre_cnt <= '0;
    else if (base_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + PREW'(1);
  end

  // Config state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_state <= CFG_IDLE;
    else     cfg_state <= cfg_nx;
  end

  // Accept in CFG_IDLE, spend exactly one cycle in CFG_APPLY.
  always_comb begin
    cfg_nx = cfg_state;
    case (cfg_state)
      CFG_IDLE:  if (cfg_valid) cfg_nx = CFG_APPLY;
      CFG_APPLY: cfg_nx = CFG_IDLE;
      default:   cfg_nx = CFG_IDLE;
    endcase
  end

  // Capture the command on acceptance so the input bus may change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_op     <= STOP;
      cmd_ch     <= '0;
      cmd_period <= '0;
    end else if ((cfg_state == CFG_IDLE) && cfg_valid) begin
      cmd_op     <= cke_op_t'(cfg_op);
      cmd_ch     <= cfg_ch;
      cmd_period <= cfg_period;
    end
  end

  // Channel select decode; an index with no matching channel leaves ch_hit empty.
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_hit[i] = (cmd_ch == CHW'(i));
    end
  end

  assign in_apply  = (cfg_state == CFG_APPLY);
  assign reject    = ~op_legal(cmd_op)
                   | (is_start(cmd_op) & (cmd_period == '0))
                   | ~(|ch_hit);
  assign cfg_ready = (cfg_state == CFG_IDLE);
  assign cfg_err   = in_apply & reject;
  assign ch_apply  = ch_hit & {NCH{in_apply & ~reject}};
  assign busy      = |ch_active;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cke_sched_ch #(.PW(PW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .base_tick (base_tick),
      .apply     (ch_apply[g]),
      .op        (cmd_op),
      .period    (cmd_period),
      .gen       (gen[g]),
      .active    (ch_active[g])
    );
  end

endmodule
